// File: rtl/fir_output_conditioner.sv
// FIR output conditioner: decimate, round, scale and saturate the filter output,
// then buffer results in a small FIFO behind a valid/ready handshake.
module fir_output_conditioner #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 14,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_sample,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear_stats,
    output logic [15:0]      sat_count,
    output logic             overflow
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DECIM - 1);

    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'((64'(1) << (OUT_W - 1)) - 64'(1));
    localparam logic signed [IN_W:0] QMIN = ~QMAX;

    localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [CW-1:0]    dec_cnt;
    logic             keep;

    logic             s1_valid;
    logic [IN_W-1:0]  s1_data;

    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] q;
    logic [OUT_W-1:0] sat_val;
    logic             sat;

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic             s2_sat;

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [OUT_W-1:0] last_data;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign keep = in_valid && (dec_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (in_valid) begin
            dec_cnt <= (dec_cnt == CMAX) ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= in_sample;
            end
        end
    end

    // One guard bit keeps the rounding add from wrapping at full scale.
    always_comb begin
        rnd     = $signed({s1_data[IN_W-1], s1_data}) + HALF;
        q       = rnd >>> SHIFT;
        sat     = 1'b0;
        sat_val = q[OUT_W-1:0];
        if (q > QMAX) begin
            sat     = 1'b1;
            sat_val = OMAX;
        end else if (q < QMIN) begin
            sat     = 1'b1;
            sat_val = OMIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_val;
                s2_sat  <= sat;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = s2_valid && (!full || pop);
    assign drop      = s2_valid && full && !pop;

    // Empty FIFO shows the last delivered sample rather than a stale slot.
    assign out_data = empty ? last_data : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s2_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
            overflow  <= 1'b0;
        end else if (clear_stats) begin
            sat_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (s2_valid && s2_sat && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Directed bench for fir_output_conditioner using a DECIM=1 and a DECIM=4 instance.
module tb_fir_output_conditioner;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] in1, in4;
    logic        v1, v4, r1, r4, c1, c4;
    logic [15:0] d1, d4, sc1, sc4;
    logic        ov1, ov4, of1, of4;

    int total = 0;
    int bad   = 0;

    logic [15:0] q1[$];
    logic [15:0] q4[$];

    always #5 clk = ~clk;

    fir_output_conditioner #(.DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .in_sample(in1), .in_valid(v1),
        .out_data(d1), .out_valid(ov1), .out_ready(r1),
        .clear_stats(c1), .sat_count(sc1), .overflow(of1)
    );

    fir_output_conditioner #(.DECIM(4)) dut4 (
        .clk(clk), .reset(reset), .in_sample(in4), .in_valid(v4),
        .out_data(d4), .out_valid(ov4), .out_ready(r4),
        .clear_stats(c4), .sat_count(sc4), .overflow(of4)
    );

    // Record each accepted sample half a cycle before its pop edge.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
            q4.delete();
        end else begin
            if (ov1 && r1) q1.push_back(d1);
            if (ov4 && r4) q4.push_back(d4);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input bit sel4,
                           input logic [15:0] exp);
        logic [31:0] g;
        g = 32'hFFFF_FFFF;
        if (!sel4 && q1.size() > 0) g = {16'h0, q1.pop_front()};
        if (sel4 && q4.size() > 0)  g = {16'h0, q4.pop_front()};
        check(tag, g, {16'h0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] val);
        v1  = 1'b1;
        in1 = val;
        tick();
    endtask

    logic [31:0] t2_in  [5] = '{32'd8191, 32'd8192, -32'sd8192, -32'sd8193, 32'd16383};
    logic [15:0] t2_exp [5] = '{16'd0, 16'd1, 16'd0, 16'hFFFF, 16'd1};

    initial begin
        reset = 1'b1;
        in1 = '0; in4 = '0;
        v1 = 0; v4 = 0; r1 = 0; r4 = 0; c1 = 0; c4 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, ov1}, 0);
        check("rst_data", {16'd0, d1}, 0);
        check("rst_sat", {16'd0, sc1}, 0);
        check("rst_ovf", {31'd0, of1}, 0);
        check("rst_valid4", {31'd0, ov4}, 0);
        reset = 1'b0;
        tick();

        // decimate by 4: keep k=0,4,8,12
        r4 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            v4  = 1'b1;
            in4 = 32'(k * 16384);
            tick();
            if (k == 1) check("t1_lat_lo", {31'd0, ov4}, 0);
            if (k == 2) check("t1_lat_hi", {31'd0, ov4}, 1);
        end
        v4 = 1'b0;
        repeat (4) tick();
        pop_chk("t1_o0", 1, 16'd0);
        pop_chk("t1_o1", 1, 16'd4);
        pop_chk("t1_o2", 1, 16'd8);
        pop_chk("t1_o3", 1, 16'd12);
        check("t1_cnt", q4.size(), 0);

        // rounding
        r1 = 1'b1;
        for (int i = 0; i < 5; i++) push1(t2_in[i]);
        v1 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) pop_chk($sformatf("t2_o%0d", i), 0, t2_exp[i]);
        check("t2_sat", {16'd0, sc1}, 0);

        // saturation
        push1(32'h7FFF_FFFF);
        push1(32'h8000_0000);
        v1 = 1'b0;
        repeat (4) tick();
        pop_chk("t3_hi", 0, 16'h7FFF);
        pop_chk("t3_lo", 0, 16'h8000);
        check("t3_sat", {16'd0, sc1}, 2);

        // overflow on full FIFO
        r1 = 1'b0;
        for (int i = 1; i <= 6; i++) push1(32'(i * 16384));
        v1 = 1'b0;
        repeat (4) tick();
        check("t4_valid", {31'd0, ov1}, 1);
        check("t4_ovf", {31'd0, of1}, 1);
        check("t4_head", {16'd0, d1}, 1);
        tick();
        check("t4_hold", {16'd0, d1}, 1);
        r1 = 1'b1;
        repeat (6) tick();
        for (int i = 1; i <= 4; i++) pop_chk($sformatf("t4_o%0d", i), 0, 16'(i));
        check("t4_empty", {31'd0, ov1}, 0);
        check("t4_last", {16'd0, d1}, 4);

        // full FIFO with simultaneous push and pop
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        check("t5_clr_sat", {16'd0, sc1}, 0);
        check("t5_clr_ovf", {31'd0, of1}, 0);
        r1 = 1'b0;
        for (int i = 10; i <= 13; i++) push1(32'(i * 16384));
        v1 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) r1 = 1'b1;
            push1(32'((14 + i) * 16384));
        end
        v1 = 1'b0;
        repeat (8) tick();
        for (int i = 10; i <= 21; i++) pop_chk($sformatf("t5_o%0d", i), 0, 16'(i));
        check("t5_ovf", {31'd0, of1}, 0);

        push1(32'h7FFF_FFFF);
        v1 = 1'b0;
        repeat (3) tick();
        check("t5_sat1", {16'd0, sc1}, 1);
        push1(32'h7FFF_FFFF);
        v1 = 1'b0;
        tick();
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        check("t5_clr_win", {16'd0, sc1}, 0);
        repeat (3) tick();
        pop_chk("t5_s0", 0, 16'h7FFF);
        pop_chk("t5_s1", 0, 16'h7FFF);

        // reset mid-stream, counter left at 1
        r4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v4  = 1'b1;
            in4 = 32'((i + 1) * 16384);
            tick();
        end
        v4 = 1'b0;
        repeat (3) tick();
        check("t6_pre_valid", {31'd0, ov4}, 1);
        check("t6_pre_head", {16'd0, d4}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, ov4}, 0);
        check("t6_rst_data", {16'd0, d4}, 0);
        check("t6_rst_valid1", {31'd0, ov1}, 0);
        tick();
        reset = 1'b0;
        r4 = 1'b1;
        v4 = 1'b1;
        in4 = 32'(7 * 16384);
        tick();
        v4 = 1'b0;
        repeat (5) tick();
        pop_chk("t6_kept", 1, 16'd7);
        check("t6_cnt", q4.size(), 0);
        check("t6_sat4", {16'd0, sc4}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
